slow_mem: RTL and testbench
===========================

Name: slow_mem

Overview:
- Behavioural-plus-synthesizable model of an off-chip memory with a fixed multi-cycle access latency and a 128-bit line interface.
- Two instances are used beside the processor chip: one serves the I-cache and one serves the D-cache. Each serves whole-line read and write refills/write-backs.
- The storage array is named `mem`, is indexed by line, and is preloadable hierarchically with $readmemb/$readmemh before reset release.

Parameters:
- LATENCY, 8, cycles from request sampling to mem_ready; legal range ≥1.
- DEPTH, 256, number of 128-bit lines in `mem`; must be a power of two.
- LINE_W, 128, line width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  read request level.
- mem_write  in  1  write request level.
- mem_addr  in  28  line address (byte address bits [31:4]).
- mem_wdata  in  128  write line data.
- mem_rdata  out  128  read line data, registered.
- mem_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; mem_ready=0; mem_rdata=0; latency counter=0.
  - `mem` contents are NOT reset, so preloaded data survives reset.
- Line index = mem_addr[log2(DEPTH)-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- States: IDLE, BUSY, DONE.
- IDLE:
  - At a rising edge with mem_read|mem_write=1, latch the address, wdata and operation, load counter=LATENCY-1, and go to BUSY.
  - If LATENCY=1, go directly to DONE.
- Simultaneous mem_read and mem_write: treated as a write. mem_rdata is unchanged.
- BUSY:
  - Counter decrements each edge. When it reaches 0, go to DONE.
  - The transaction uses the latched values. Request inputs are ignored while BUSY, including deassertion: an aborted request still completes.
- DONE:
  - Lasts exactly one cycle with mem_ready=1.
  - Read: mem_rdata already holds mem[idx], loaded on the edge that entered DONE.
  - Write: mem[idx] was written with the latched wdata on the edge that entered DONE.
  - Next state is always IDLE. Request levels during the DONE cycle are ignored, so the requester may keep its request asserted during the ready cycle.
- Timing: a request first sampled at edge k gives mem_ready high during the cycle after edge k+LATENCY. The next request can be sampled no earlier than edge k+LATENCY+2.
- mem_rdata holds its value until the next read completes; it is not cleared when mem_ready falls.
- Reset asserted mid-transaction: the transaction is dropped and no memory write occurs unless its commit edge already passed. The interface returns to IDLE.
- Back-to-back write then read to the same line: the read returns the newly written data.

Decomposition:
- Shared package mem_if_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Constants LINE_W=128 and ADDR_W=28, reused by the cache blocks.
- Single module; no sub-module. The storage array stays in this module as `mem` so the hierarchical preload path inst.mem works.

Test Plan:
- Preload mem[3]=128'h0123…CDEF. Hold mem_read=1, addr=3 from edge 0 → mem_ready=1 for exactly one cycle after edge 8, with mem_rdata=mem[3]; mem_ready=0 on every other cycle.
- Write addr=5, wdata=128'hA5…A5 (held until ready), then read addr=5 → ready after 8 cycles on each transaction; the read returns 128'hA5…A5. mem_rdata is unchanged by the write.
- Pulse mem_read for 1 cycle only, addr=7 → the transaction still completes with ready at LATENCY and mem_rdata=mem[7].
- Assert read and write together, addr=2, wdata=128'h1 → treated as a write: mem[2]=1 and mem_rdata unchanged.
- Address 28'h100 with DEPTH=256 → accesses line 0 (wrap-around).
- Drop rst_n during BUSY of a write to addr=9 → mem_ready stays 0 and mem[9] is unchanged. After release, a new read to 9 completes normally with the original preloaded value.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the off-chip line memory and the caches that use it.
package mem_if_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_e;

endpackage

// File: rtl/slow_mem.sv
// Fixed-latency line memory: one request at a time, completion signalled by a one-cycle
// mem_ready pulse. The array `mem` is not reset so a hierarchical preload survives reset.
module slow_mem
    import mem_if_pkg::*;
#(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LINE_W  = mem_if_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [LINE_W-1:0] mem [DEPTH];

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;
    logic [LINE_W-1:0] rdata_q;

    logic              latch_en;
    logic              commit;
    logic [IDX_W-1:0]  op_idx;
    logic [LINE_W-1:0] op_wdata;
    logic              op_write;

    // Upper address bits select nothing; lines wrap modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        op_write = write_q;
        case (state_q)
            IDLE: begin
                // With LATENCY=1 the commit happens on the sampling edge, so use live inputs.
                op_idx   = mem_addr[IDX_W-1:0];
                op_wdata = mem_wdata;
                op_write = mem_write;
                if (mem_read || mem_write) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                idx_q   <= mem_addr[IDX_W-1:0];
                wdata_q <= mem_wdata;
                write_q <= mem_write;
            end
            if (commit && !op_write) begin
                rdata_q <= mem[op_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && op_write) begin
            mem[op_idx] <= op_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (state_q == DONE);

endmodule

// File: tb/tb_slow_mem.sv
// Directed bench for slow_mem: table of line transactions plus reset-abort sequence.
module tb_slow_mem;

    localparam logic [127:0] D3 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D7 = 128'hDEADBEEFCAFEF00D1122334455667788;
    localparam logic [127:0] D9 = 128'h99999999888888887777777766666666;
    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] W0 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [127:0] WX = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic         hold;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    slow_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge leaving DONE.
    task automatic run_txn(input int id, input vec_t v);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        @(posedge clk);
        #1;
        if (!v.hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = 28'h0;
            mem_wdata = '0;
        end
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk($sformatf("latency[%0d]", id), 128'(lat), 128'd8);
        chk($sformatf("rdata[%0d]", id), mem_rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        chk($sformatf("pulse[%0d]", id), {127'd0, mem_ready}, 128'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        bit any_ready;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dut.mem[3] = D3;
        dut.mem[7] = D7;
        dut.mem[9] = D9;

        vecs[0] = '{1'b1, 1'b0, 28'h3,     '0,     1'b1, D3};
        vecs[1] = '{1'b0, 1'b1, 28'h5,     A5,     1'b1, D3};
        vecs[2] = '{1'b1, 1'b0, 28'h5,     '0,     1'b1, A5};
        vecs[3] = '{1'b1, 1'b0, 28'h7,     '0,     1'b0, D7};
        vecs[4] = '{1'b1, 1'b1, 28'h2,     128'h1, 1'b1, D7};
        vecs[5] = '{1'b1, 1'b0, 28'h2,     '0,     1'b1, 128'h1};
        vecs[6] = '{1'b0, 1'b1, 28'h100,   W0,     1'b0, 128'h1};
        vecs[7] = '{1'b1, 1'b0, 28'h0,     '0,     1'b1, W0};
        vecs[8] = '{1'b1, 1'b0, 28'hF03,   '0,     1'b0, D3};

        #12;
        chk("reset_ready", {127'd0, mem_ready}, 128'd0);
        chk("reset_rdata", mem_rdata, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset during the busy phase of a write to line 9 must drop it.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h9;
        mem_wdata = WX;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {127'd0, mem_ready}, 128'd0);
        chk("abort_rdata", mem_rdata, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        any_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) any_ready = 1'b1;
        end
        chk("abort_no_ready", {127'd0, any_ready}, 128'd0);
        run_txn(9, '{1'b1, 1'b0, 28'h9, '0, 1'b1, D9});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
